// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read feeding a 2-entry
// {pc, instr} buffer, with jump/branch redirect that flushes stale entries.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [31:0] Pc_out,
    output logic        Instr_valid,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

    logic        pop, redirect, ack;
    logic [1:0]  occ_pop;
    logic [31:0] pc_inc, target;
    logic [3:0]  jump_hi;

    always_comb begin
        pop      = (occ_q != 2'd0) && !Stall;
        redirect = pop && (Branch_taken || Jump);
        ack      = Imem_ack && req_q;
        occ_pop  = occ_q - {1'b0, pop};
        pc_inc   = fetch_pc_q + 32'd4;
        // (head pc + 4)[31:28] without a full adder: carry only when [27:2] is all ones
        jump_hi  = pc0_q[31:28] + {3'b000, &pc0_q[27:2]};
        target   = Branch_taken ? Branch_addr : {jump_hi, ins0_q[25:0], 2'b00};

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_pop;
        req_d      = req_q;
        addr_d     = addr_q;
        pc0_d      = pop ? pc1_q : pc0_q;
        ins0_d     = pop ? ins1_q : ins0_q;
        pc1_d      = pc1_q;
        ins1_d     = ins1_q;

        case (state_q)
            IDLE: begin
                req_d   = 1'b1;
                addr_d  = fetch_pc_q;
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    occ_d      = 2'd0;
                    fetch_pc_d = target;
                    if (ack) addr_d = target;
                    else     state_d = DISCARD;
                end else if (ack) begin
                    if (occ_pop == 2'd0) begin
                        pc0_d  = fetch_pc_q;
                        ins0_d = Imem_rdata;
                    end else begin
                        pc1_d  = fetch_pc_q;
                        ins1_d = Imem_rdata;
                    end
                    occ_d      = occ_pop + 2'd1;
                    fetch_pc_d = pc_inc;
                    if (occ_pop == 2'd0) begin
                        addr_d = pc_inc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    occ_d      = 2'd0;
                    fetch_pc_d = target;
                    req_d      = 1'b1;
                    addr_d     = target;
                    state_d    = FETCH;
                end else if (pop) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // buffer is empty here, so the redirect branch is defensive only
                if (redirect) fetch_pc_d = target;
                if (ack) begin
                    addr_d  = fetch_pc_d;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            occ_q      <= 2'd0;
            req_q      <= 1'b0;
            addr_q     <= 32'd0;
            pc0_q      <= 32'd0;
            pc1_q      <= 32'd0;
            ins0_q     <= 32'd0;
            ins1_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
        end
    end

    assign Imem_req    = req_q;
    assign Imem_addr   = addr_q;
    assign Instr       = ins0_q;
    assign Op          = ins0_q[31:26];
    assign Pc_out      = pc0_q;
    assign Instr_valid = (occ_q != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack = 1'b0;
    logic [31:0] Imem_rdata = 32'd0;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [31:0] Pc_out;
    logic        Instr_valid;
    logic        Stall = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_addr = 32'd0;

    always #5 Clk = ~Clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Rst(Rst),
        .Imem_req(Imem_req), .Imem_addr(Imem_addr),
        .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
        .Instr(Instr), .Op(Op), .Pc_out(Pc_out), .Instr_valid(Instr_valid),
        .Stall(Stall), .Jump(Jump), .Branch_taken(Branch_taken),
        .Branch_addr(Branch_addr)
    );

    int checks = 0;
    int errors = 0;

    // reference model: buffered pairs plus the one outstanding request
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        q[$];
    logic        m_req = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] fpc = RST_PC;
    bit          m_disc = 1'b0;
    bit          m_rst = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0800_0010;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit          consume, redir, got;
        logic [31:0] tgt, hp4;
        ent_t        e;
        m_rst = Rst;
        if (Rst) begin
            q.delete();
            m_req = 1'b0; m_addr = 32'd0; fpc = RST_PC; m_disc = 1'b0;
            return;
        end
        consume = (q.size() != 0) && !Stall;
        redir   = consume && (Branch_taken || Jump);
        got     = m_req && Imem_ack;
        tgt     = Branch_addr;
        if (q.size() != 0 && !Branch_taken) begin
            hp4 = q[0].pc + 32'd4;
            tgt = {hp4[31:28], q[0].ins[25:0], 2'b00};
        end
        if (consume) void'(q.pop_front());
        if (redir) begin
            q.delete();
            fpc = tgt;
            if (!m_req) begin
                m_req = 1'b1; m_addr = tgt;
            end else if (got) begin
                m_addr = tgt; m_disc = 1'b0;
            end else begin
                m_disc = 1'b1;
            end
        end else if (got) begin
            if (m_disc) begin
                m_disc = 1'b0; m_addr = fpc;
            end else begin
                e.pc = fpc; e.ins = Imem_rdata;
                q.push_back(e);
                fpc = fpc + 32'd4;
                if (q.size() < 2) m_addr = fpc;
                else m_req = 1'b0;
            end
        end else if (!m_req && q.size() < 2) begin
            m_req = 1'b1; m_addr = fpc;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
        chk("model_req", 32'(Imem_req), 32'(m_req));
        if (m_req) chk("model_addr", Imem_addr, m_addr);
        chk("model_valid", 32'(Instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("model_pc", Pc_out, q[0].pc);
            chk("model_instr", Instr, q[0].ins);
            chk("model_op", 32'(Op), 32'(q[0].ins[31:26]));
        end
        if (m_rst) begin
            chk("rst_pc", Pc_out, 32'd0);
            chk("rst_instr", Instr, 32'd0);
            chk("rst_addr", Imem_addr, 32'd0);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1; Imem_ack = 1'b0; Stall = 1'b0; Jump = 1'b0; Branch_taken = 1'b0;
        step();
        Rst = 1'b0;
    endtask

    task automatic drive_ack(input logic a);
        Imem_ack   = a;
        Imem_rdata = a ? mem(Imem_addr) : $urandom;
    endtask

    typedef struct {
        logic        rst, stall, ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // reset, zero-wait streaming, 5-cycle stall filling the buffer, drain
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd16, 1'b1, 32'd12};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd12};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd12};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd12};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd12};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 1'b1, 32'd16};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd20};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd24, 1'b0, 32'd0};

        for (int i = 0; i < 14; i++) begin
            Rst = tbl[i].rst; Stall = tbl[i].stall; Jump = 1'b0; Branch_taken = 1'b0;
            drive_ack(tbl[i].ack);
            step();
            chk($sformatf("tbl%0d_req", i), 32'(Imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), Imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(Instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), Pc_out, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), Instr, mem(tbl[i].e_pc));
            end
        end

        // jump from head 0x40 back to itself, zero-wait memory
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Instr_valid && Pc_out == 32'h40) begin
                found = 1'b1;
                break;
            end
            drive_ack(Imem_req);
            step();
        end
        chk("jmp_reach", 32'(found), 32'd1);
        if (found) begin
            Jump = 1'b1; drive_ack(Imem_req);
            step();
            Jump = 1'b0;
            chk("jmp_flush_valid", 32'(Instr_valid), 32'd0);
            chk("jmp_addr", Imem_addr, 32'h40);
            drive_ack(Imem_req);
            step();
            chk("jmp_pc", Pc_out, 32'h40);
            chk("jmp_instr", Instr, 32'h0800_0010);
        end

        // branch while a 3-cycle request to 0x8 is pending
        do_reset();
        drive_ack(1'b0); step();
        drive_ack(1'b1); step();
        drive_ack(1'b1); step();
        chk("br_pending_addr", Imem_addr, 32'h8);
        Branch_taken = 1'b1; Branch_addr = 32'h100; drive_ack(1'b0);
        step();
        Branch_taken = 1'b0;
        chk("br_disc_valid", 32'(Instr_valid), 32'd0);
        chk("br_disc_addr", Imem_addr, 32'h8);
        drive_ack(1'b0); step();
        chk("br_disc_hold", Imem_addr, 32'h8);
        drive_ack(1'b1); step();
        chk("br_drop_valid", 32'(Instr_valid), 32'd0);
        chk("br_new_addr", Imem_addr, 32'h100);
        drive_ack(1'b1); step();
        chk("br_pc", Pc_out, 32'h100);
        chk("br_valid", 32'(Instr_valid), 32'd1);

        // branch and jump together: branch target wins
        Branch_taken = 1'b1; Jump = 1'b1; Branch_addr = 32'h200; drive_ack(1'b1);
        step();
        Branch_taken = 1'b0; Jump = 1'b0;
        chk("prio_addr", Imem_addr, 32'h200);
        drive_ack(1'b1); step();
        chk("prio_pc", Pc_out, 32'h200);

        // reset mid-fetch with an ack in the reset cycle
        Rst = 1'b1; drive_ack(1'b1);
        step();
        chk("rst_mid_valid", 32'(Instr_valid), 32'd0);
        chk("rst_mid_req", 32'(Imem_req), 32'd0);
        Rst = 1'b0; drive_ack(1'b0);
        step();
        chk("rst_first_addr", Imem_addr, RST_PC);
        chk("rst_first_req", 32'(Imem_req), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Rst          = ($urandom_range(0, 199) == 0);
            Stall        = ($urandom_range(0, 9) < 3);
            Jump         = ($urandom_range(0, 9) == 0);
            Branch_taken = ($urandom_range(0, 9) == 0);
            Branch_addr  = 32'($urandom_range(0, 1023)) << 2;
            drive_ack(Imem_req && ($urandom_range(0, 1) == 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
